// File: rtl/arquitetura_pio_pkg.sv
// arquitetura_pio_pkg: shared op encodings, FSM states and STATUS layout for the PIO output block.
package arquitetura_pio_pkg;
   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_SET   = 2'd1,
      OP_CLR   = 2'd2,
      OP_CTRL  = 2'd3
   } op_e;
   typedef enum logic {
      S_IDLE,
      S_PENDING
   } state_e;
   localparam int STAT_PENDING = 0;
   localparam int STAT_STALL   = 1;
   localparam int STAT_CNT_LSB = 16;
   function automatic int idx_w(input int ch);
      return ch > 1 ? $clog2(ch) : 1;
   endfunction
endpackage

// File: rtl/arquitetura_pio_out_if.sv
// arquitetura_pio_out_if: Avalon-MM slave bus plus valid/ready output stream of the PIO block.
interface arquitetura_pio_out_if
   import arquitetura_pio_pkg::*;
#(
   parameter int CH     = 4,
   parameter int DATA_W = 32
);
   localparam int ADDR_W = idx_w(CH) + 2;
   logic [ADDR_W-1:0]    address;
   logic                 chipselect;
   logic                 write_n;
   logic [31:0]          writedata;
   logic [31:0]          readdata;
   logic                 waitrequest;
   logic [CH*DATA_W-1:0] out_port;
   logic                 out_valid;
   logic                 out_ready;
   modport slave (
      input  address, chipselect, write_n, writedata, out_ready,
      output readdata, waitrequest, out_port, out_valid
   );
   modport master (
      output address, chipselect, write_n, writedata, out_ready,
      input  readdata, waitrequest, out_port, out_valid
   );
endinterface

// File: rtl/arquitetura_pio_chan.sv
// arquitetura_pio_chan: one shadow channel register with write/set/clear updates.
module arquitetura_pio_chan
   import arquitetura_pio_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  op_e               op_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] shadow_d_o,
   output logic [DATA_W-1:0] shadow_q_o
);
   logic [DATA_W-1:0] shadow_q, shadow_d;
   always_comb begin
      shadow_d = !we_i              ? shadow_q :
                 op_i == OP_WRITE   ? wdata_i :
                 op_i == OP_SET     ? shadow_q | wdata_i :
                 op_i == OP_CLR     ? shadow_q & ~wdata_i : shadow_q;
   end
   always_ff @(posedge clk) begin
      if (reset) shadow_q <= RESET_VALUE;
      else shadow_q <= shadow_d;
   end
   assign shadow_d_o = shadow_d;
   assign shadow_q_o = shadow_q;
endmodule

// File: rtl/arquitetura_pio_out.sv
// arquitetura_pio_out: shadowed multi-channel PIO output with atomic commit and valid/ready handshake.
module arquitetura_pio_out
   import arquitetura_pio_pkg::*;
#(
   parameter int          CH          = 4,
   parameter int          DATA_W      = 32,
   parameter logic [31:0] RESET_VALUE = '0,
   parameter bit          AUTO_COMMIT = 1'b0
) (
   input logic                  clk,
   input logic                  reset,
   arquitetura_pio_out_if.slave bus
);
   localparam int IDX_W = idx_w(CH);
   localparam int ADDR_W = IDX_W + 2;
   op_e                  op;
   logic [IDX_W-1:0]     idx;
   logic                 wr, idx_ok, shadow_wr, shadow_we, commit_req, commit_acc, stall_clr, wait_w;
   logic [DATA_W-1:0]    shadow_q [CH];
   logic [CH*DATA_W-1:0] shadow_d;
   logic [DATA_W-1:0]    rd_shadow;
   logic [31:0]          status;
   state_e               state_q, state_d;
   logic [CH*DATA_W-1:0] live_q, live_d;
   logic [15:0]          count_q, count_d;
   logic                 stall_q, stall_d;
   assign op         = op_e'(bus.address[ADDR_W-1 -: 2]);
   assign idx        = bus.address[IDX_W-1:0];
   assign wr         = bus.chipselect && !bus.write_n;
   assign idx_ok     = int'(idx) < CH;
   assign shadow_wr  = wr && op != OP_CTRL && idx_ok;
   // With AUTO_COMMIT every accepted shadow write is itself a commit and can be stalled.
   assign commit_req = wr && ((op == OP_CTRL && idx == '0) || (AUTO_COMMIT && shadow_wr));
   assign wait_w     = state_q == S_PENDING && commit_req;
   assign commit_acc = commit_req && !wait_w;
   assign shadow_we  = shadow_wr && !wait_w;
   assign stall_clr  = wr && !wait_w && op == OP_CTRL && idx == IDX_W'(1) && bus.writedata[STAT_STALL];
   for (genvar i = 0; i < CH; i++) begin : g_chan
      arquitetura_pio_chan #(
         .DATA_W      (DATA_W),
         .RESET_VALUE (RESET_VALUE[DATA_W-1:0])
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .we_i       (shadow_we && idx == IDX_W'(i)),
         .op_i       (op),
         .wdata_i    (bus.writedata[DATA_W-1:0]),
         .shadow_d_o (shadow_d[i*DATA_W +: DATA_W]),
         .shadow_q_o (shadow_q[i])
      );
   end
   always_comb begin
      rd_shadow = '0;
      for (int c = 0; c < CH; c++) if (idx == IDX_W'(c)) rd_shadow = shadow_q[c];
   end
   always_comb begin
      status = '0;
      status[STAT_CNT_LSB +: 16] = count_q;
      status[STAT_STALL]         = stall_q;
      status[STAT_PENDING]       = state_q == S_PENDING;
   end
   always_comb begin
      state_d = state_q == S_IDLE ? (commit_acc ? S_PENDING : S_IDLE) : (bus.out_ready ? S_IDLE : S_PENDING);
      live_d  = commit_acc ? shadow_d : live_q;
      count_d = count_q + {15'd0, commit_acc};
      stall_d = wait_w ? 1'b1 : stall_clr ? 1'b0 : stall_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         live_q  <= {CH{RESET_VALUE[DATA_W-1:0]}};
         count_q <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end
   assign bus.readdata    = (op == OP_WRITE && idx_ok)        ? 32'(rd_shadow) :
                            (op == OP_CTRL && idx == '0)       ? 32'(live_q[DATA_W-1:0]) :
                            (op == OP_CTRL && idx == IDX_W'(1)) ? status : '0;
   assign bus.waitrequest = wait_w;
   assign bus.out_port    = live_q;
   assign bus.out_valid   = state_q == S_PENDING;
endmodule

// File: tb/tb_arquitetura_pio_out.sv
// tb_arquitetura_pio_out: directed checks of a default instance and an AUTO_COMMIT CH=3 DATA_W=8 instance.
module tb_arquitetura_pio_out;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   arquitetura_pio_out_if #(.CH(4), .DATA_W(32)) a_if ();
   arquitetura_pio_out_if #(.CH(3), .DATA_W(8))  b_if ();
   arquitetura_pio_out #(.CH(4), .DATA_W(32), .RESET_VALUE(32'h0), .AUTO_COMMIT(1'b0)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if.slave)
   );
   arquitetura_pio_out #(.CH(3), .DATA_W(8), .RESET_VALUE(32'h1C3), .AUTO_COMMIT(1'b1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if.slave)
   );
   always #5 clk = ~clk;

   task automatic a_write(input logic [3:0] addr, input logic [31:0] data);
      int n = 0;
      a_if.address = addr; a_if.writedata = data; a_if.chipselect = 1'b1; a_if.write_n = 1'b0;
      @(negedge clk);
      while (a_if.waitrequest && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (a_if.waitrequest !== 1'b0) begin errors++; $display("FAIL a_write_timeout addr=%h waitrequest=%b want 0", addr, a_if.waitrequest); end
      @(posedge clk); #1;
      a_if.chipselect = 1'b0; a_if.write_n = 1'b1;
   endtask

   task automatic b_write(input logic [3:0] addr, input logic [31:0] data);
      int n = 0;
      b_if.address = addr; b_if.writedata = data; b_if.chipselect = 1'b1; b_if.write_n = 1'b0;
      @(negedge clk);
      while (b_if.waitrequest && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (b_if.waitrequest !== 1'b0) begin errors++; $display("FAIL b_write_timeout addr=%h waitrequest=%b want 0", addr, b_if.waitrequest); end
      @(posedge clk); #1;
      b_if.chipselect = 1'b0; b_if.write_n = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_if.address = 4'hC; a_if.chipselect = 1'b1; a_if.write_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_if.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b want 0", a_if.waitrequest); end
      a_if.chipselect = 1'b0; a_if.write_n = 1'b1;
      reset = 1'b0;
      @(posedge clk); #1;
      a_if.address = 4'h2; #1;
      checks++; if (a_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_read_idx2 got=%h want 00000000", a_if.readdata); end
      checks++; if (a_if.out_port !== 128'h0) begin errors++; $display("FAIL reset_out_port got=%h want 0", a_if.out_port); end
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want 0", a_if.out_valid); end
      a_if.address = 4'hD; #1;
      checks++; if (a_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_status got=%h want 00000000", a_if.readdata); end
      checks++; if (b_if.out_port !== 24'hC3C3C3) begin errors++; $display("FAIL reset_b_out_port got=%h want c3c3c3", b_if.out_port); end
   endtask

   task automatic test_shadow_ops();
      a_write(4'h1, 32'hF0F0F0F0);
      a_write(4'h5, 32'h0000000F);
      a_write(4'h9, 32'hF0000000);
      a_if.address = 4'h1; #1;
      checks++; if (a_if.readdata !== 32'h00F0F0FF) begin errors++; $display("FAIL shadow1_read got=%h want 00f0f0ff", a_if.readdata); end
      a_if.address = 4'h5; #1;
      checks++; if (a_if.readdata !== 32'h0) begin errors++; $display("FAIL op1_read got=%h want 00000000", a_if.readdata); end
      checks++; if (a_if.out_port !== 128'h0) begin errors++; $display("FAIL shadow_no_live got=%h want 0", a_if.out_port); end
      a_write(4'hE, 32'hFFFFFFFF);
      a_if.address = 4'hE; #1;
      checks++; if (a_if.readdata !== 32'h0) begin errors++; $display("FAIL op3_idx2_read got=%h want 00000000", a_if.readdata); end
      a_if.out_ready = 1'b1;
      @(posedge clk); #1;
      a_if.out_ready = 1'b0;
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored out_valid=%b want 0", a_if.out_valid); end
   endtask

   task automatic test_commit();
      a_write(4'hC, 32'h0);
      checks++; if (a_if.out_port[63:32] !== 32'h00F0F0FF) begin errors++; $display("FAIL commit_ch1 got=%h want 00f0f0ff", a_if.out_port[63:32]); end
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL commit_valid got=%b want 1", a_if.out_valid); end
      a_if.address = 4'hD; #1;
      checks++; if (a_if.readdata !== 32'h00010001) begin errors++; $display("FAIL commit_status got=%h want 00010001", a_if.readdata); end
   endtask

   task automatic test_pending_shadow();
      a_write(4'h0, 32'h12345678);
      checks++; if (a_if.out_port[31:0] !== 32'h0) begin errors++; $display("FAIL pending_live_ch0 got=%h want 00000000", a_if.out_port[31:0]); end
      a_if.address = 4'h0; #1;
      checks++; if (a_if.readdata !== 32'h12345678) begin errors++; $display("FAIL pending_shadow0 got=%h want 12345678", a_if.readdata); end
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL pending_valid got=%b want 1", a_if.out_valid); end
   endtask

   task automatic test_back_to_back();
      a_if.address = 4'hC; a_if.writedata = 32'h0; a_if.chipselect = 1'b1; a_if.write_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (a_if.waitrequest !== 1'b1) begin errors++; $display("FAIL stall_cycle%0d wait=%b want 1", k, a_if.waitrequest); end
         @(posedge clk); #1;
      end
      checks++; if (a_if.out_port[31:0] !== 32'h0) begin errors++; $display("FAIL stall_live_stable got=%h want 00000000", a_if.out_port[31:0]); end
      a_if.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (a_if.waitrequest !== 1'b1) begin errors++; $display("FAIL ready_cycle_wait got=%b want 1", a_if.waitrequest); end
      @(posedge clk); #1;
      a_if.out_ready = 1'b0;
      @(negedge clk);
      checks++; if (a_if.waitrequest !== 1'b0) begin errors++; $display("FAIL idle_wait got=%b want 0", a_if.waitrequest); end
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b want 0", a_if.out_valid); end
      @(posedge clk); #1;
      a_if.chipselect = 1'b0; a_if.write_n = 1'b1;
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL second_commit_valid got=%b want 1", a_if.out_valid); end
      checks++; if (a_if.out_port[63:0] !== 64'h00F0F0FF_12345678) begin errors++; $display("FAIL second_commit_live got=%h want 00f0f0ff12345678", a_if.out_port[63:0]); end
      a_if.address = 4'hD; #1;
      checks++; if (a_if.readdata !== 32'h00020003) begin errors++; $display("FAIL stall_status got=%h want 00020003", a_if.readdata); end
      a_write(4'hD, 32'h2);
      a_if.address = 4'hD; #1;
      checks++; if (a_if.readdata !== 32'h00020001) begin errors++; $display("FAIL stall_clear got=%h want 00020001", a_if.readdata); end
   endtask

   task automatic test_auto_commit();
      b_write(4'h3, 32'h1A5);
      checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL auto_bad_idx_valid got=%b want 0", b_if.out_valid); end
      checks++; if (b_if.out_port !== 24'hC3C3C3) begin errors++; $display("FAIL auto_bad_idx_port got=%h want c3c3c3", b_if.out_port); end
      b_if.address = 4'hD; #1;
      checks++; if (b_if.readdata !== 32'h0) begin errors++; $display("FAIL auto_bad_idx_status got=%h want 00000000", b_if.readdata); end
      b_write(4'h0, 32'h1A5);
      checks++; if (b_if.out_port !== 24'hC3C3A5) begin errors++; $display("FAIL auto_commit_port got=%h want c3c3a5", b_if.out_port); end
      checks++; if (b_if.out_valid !== 1'b1) begin errors++; $display("FAIL auto_commit_valid got=%b want 1", b_if.out_valid); end
      b_if.address = 4'h0; #1;
      checks++; if (b_if.readdata !== 32'h000000A5) begin errors++; $display("FAIL auto_shadow_read got=%h want 000000a5", b_if.readdata); end
      b_if.address = 4'h5; b_if.writedata = 32'h0F; b_if.chipselect = 1'b1; b_if.write_n = 1'b0;
      @(negedge clk);
      checks++; if (b_if.waitrequest !== 1'b1) begin errors++; $display("FAIL auto_stall_wait got=%b want 1", b_if.waitrequest); end
      @(posedge clk); #1;
      checks++; if (b_if.out_port !== 24'hC3C3A5) begin errors++; $display("FAIL auto_stall_port got=%h want c3c3a5", b_if.out_port); end
      b_if.out_ready = 1'b1;
      @(posedge clk); #1;
      b_if.out_ready = 1'b0;
      @(negedge clk);
      checks++; if (b_if.waitrequest !== 1'b0) begin errors++; $display("FAIL auto_release_wait got=%b want 0", b_if.waitrequest); end
      @(posedge clk); #1;
      b_if.chipselect = 1'b0; b_if.write_n = 1'b1;
      checks++; if (b_if.out_port !== 24'hC3CFA5) begin errors++; $display("FAIL auto_set_port got=%h want c3cfa5", b_if.out_port); end
      b_if.address = 4'hD; #1;
      checks++; if (b_if.readdata !== 32'h00020003) begin errors++; $display("FAIL auto_status got=%h want 00020003", b_if.readdata); end
   endtask

   task automatic test_reset_pending();
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_pending got=%b want 1", a_if.out_valid); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_pend_valid got=%b want 0", a_if.out_valid); end
      checks++; if (a_if.out_port !== 128'h0) begin errors++; $display("FAIL rst_pend_port got=%h want 0", a_if.out_port); end
      a_if.address = 4'hD; #1;
      checks++; if (a_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_pend_status got=%h want 00000000", a_if.readdata); end
      checks++; if (b_if.out_port !== 24'hC3C3C3) begin errors++; $display("FAIL rst_b_port got=%h want c3c3c3", b_if.out_port); end
      @(posedge clk); #1;
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_replay got=%b want 0", a_if.out_valid); end
   endtask

   initial begin
      a_if.address = '0; a_if.chipselect = 1'b0; a_if.write_n = 1'b1; a_if.writedata = '0; a_if.out_ready = 1'b0;
      b_if.address = '0; b_if.chipselect = 1'b0; b_if.write_n = 1'b1; b_if.writedata = '0; b_if.out_ready = 1'b0;
      test_reset();
      test_shadow_ops();
      test_commit();
      test_pending_shadow();
      test_back_to_back();
      test_auto_commit();
      test_reset_pending();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
